// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
//
// Shares one single-port framebuffer RAM (RGB332, one byte per pixel)
// between VGA scanout and a pixel writer. Scanout has priority: it prefetches
// pixels into a small FIFO and delivers one pixel per pixel-clock enable
// while the display area is active. The writer uses a req/ack handshake.
// A wait counter forces a pending write through after MAX_WAIT denied cycles,
// so the writer can never be starved.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   pix_ce          pixel-clock enable (one pixel consumed/emitted per pulse)
//   frame_start     single-cycle pulse before the first active pixel
//   active          current pixel lies inside the displayed area
//   pix_out         RGB332 pixel to the DAC pins
//   underrun        sticky: an active pixel found the FIFO empty this frame
//   wr_req/wr_addr/wr_data/wr_ack   writer handshake
//   ram_en/ram_we/ram_addr/ram_wdata/ram_rdata   framebuffer RAM port
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int FB_PIXELS  = 307200,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_WAIT   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_ce,
  input  logic              frame_start,
  input  logic              active,
  output logic [7:0]        pix_out,
  output logic              underrun,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  // Two spare bits: count plus up to two reads in flight must not wrap.
  localparam int CNT_W  = PTR_W + 2;
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FB_PIXELS - 1);
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_MAX_C = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e              state_q,     state_d;
  logic [ADDR_W-1:0]   rd_addr_q,   rd_addr_d;
  logic [PTR_W-1:0]    wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q,    rd_ptr_d;
  logic [CNT_W-1:0]    count_q,     count_d;
  logic                rd_pend_q,   rd_pend_d;
  logic [WAIT_W-1:0]   wait_cnt_q,  wait_cnt_d;
  logic                wr_ack_q,    wr_ack_d;
  logic                ram_en_q,    ram_en_d;
  logic                ram_we_q,    ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q,  ram_addr_d;
  logic [7:0]          ram_wdata_q, ram_wdata_d;
  logic [7:0]          pix_out_q,   pix_out_d;
  logic                underrun_q,  underrun_d;

  logic [7:0]          fifo_mem [FIFO_DEPTH];

  logic                port_rd;
  logic [CNT_W-1:0]    in_flight;
  logic                rd_elig;
  logic                wr_elig;
  logic                force_wr;
  logic                grant_wr;
  logic                grant_rd;
  logic                push;
  logic                pop;
  logic                fifo_empty;

  // A read is in flight while it sits on the RAM port (its data appears next
  // cycle) and during the cycle its data is on ram_rdata (pushed at the end
  // of that cycle). Both must be reserved in the FIFO before issuing another.
  // frame_start blocks new reads for one cycle so the flush is clean.
  always_comb begin
    port_rd    = ram_en_q & ~ram_we_q;
    in_flight  = CNT_W'(port_rd) + CNT_W'(rd_pend_q);
    fifo_empty = (count_q == '0);
    rd_elig    = (state_q == FETCH) && !frame_start &&
                 ((count_q + in_flight) < DEPTH_C);
    // Skipping the cycle right after an ack stops a second write while the
    // writer is still lowering wr_req.
    wr_elig    = wr_req && !wr_ack_q;
    force_wr   = wr_elig && (wait_cnt_q == WAIT_MAX_C);
    grant_wr   = force_wr || (wr_elig && !rd_elig);
    grant_rd   = rd_elig && !force_wr;
    push       = rd_pend_q && !frame_start;
    pop        = pix_ce && active && !fifo_empty && !frame_start;
  end

  // Next-state logic: RAM port grant, wait counter, FIFO bookkeeping and
  // pixel consumption. frame_start is applied last so it overrides every
  // other update to the fetch side, including a same-cycle pop.
  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    wait_cnt_d  = wait_cnt_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    pix_out_d   = pix_out_q;
    underrun_d  = underrun_q;
    wr_ack_d    = 1'b0;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    rd_pend_d   = port_rd && !frame_start;

    if (grant_wr) begin
      ram_en_d    = 1'b1;
      ram_we_d    = 1'b1;
      ram_addr_d  = wr_addr;
      ram_wdata_d = wr_data;
      wr_ack_d    = 1'b1;
    end else if (grant_rd) begin
      ram_en_d   = 1'b1;
      ram_addr_d = rd_addr_q;
      rd_addr_d  = rd_addr_q + ADDR_W'(1);
      if (rd_addr_q == LAST_ADDR) begin
        state_d = DONE;
      end
    end

    if (!wr_req || grant_wr) begin
      wait_cnt_d = '0;
    end else if (wr_elig && (wait_cnt_q != WAIT_MAX_C)) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    // An empty active pixel shows black and the frame slips; there is no
    // resync until the next frame_start.
    if (pix_ce && !frame_start) begin
      if (!active) begin
        pix_out_d = 8'h00;
      end else if (fifo_empty) begin
        pix_out_d  = 8'h00;
        underrun_d = 1'b1;
      end else begin
        pix_out_d = fifo_mem[rd_ptr_q];
      end
    end

    if (frame_start) begin
      state_d    = FETCH;
      rd_addr_d  = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      underrun_d = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_pend_q   <= 1'b0;
      wait_cnt_q  <= '0;
      wr_ack_q    <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      pix_out_q   <= '0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_pend_q   <= rd_pend_d;
      wait_cnt_q  <= wait_cnt_d;
      wr_ack_q    <= wr_ack_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      pix_out_q   <= pix_out_d;
      underrun_q  <= underrun_d;
    end
  end

  // FIFO storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= ram_rdata;
    end
  end

  assign pix_out   = pix_out_q;
  assign underrun  = underrun_q;
  assign wr_ack    = wr_ack_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vga_fb_arbiter
//
// Directed bench for vga_fb_arbiter with a 16-pixel frame. A synchronous RAM
// model preloaded with addr*3 backs the RAM port; a shadow array holds the
// expected framebuffer contents for pixel comparisons.
// ---------------------------------------------------------------------------
module tb_vga_fb_arbiter;

  localparam int ADDR_W     = 8;
  localparam int FB_PIXELS  = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_WAIT   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              pix_ce;
  logic              frame_start;
  logic              active;
  logic [7:0]        pix_out;
  logic              underrun;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_ack;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter #(
    .ADDR_W    (ADDR_W),
    .FB_PIXELS (FB_PIXELS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .MAX_WAIT  (MAX_WAIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_ce     (pix_ce),
    .frame_start(frame_start),
    .active     (active),
    .pix_out    (pix_out),
    .underrun   (underrun),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  // Synchronous single-port RAM: read data valid one clk after the access.
  logic [7:0] mem [256];
  logic       preloadReq;

  always @(posedge clk) begin
    if (preloadReq) begin
      for (int i = 0; i < 256; i++) mem[i] <= (i < FB_PIXELS) ? 8'(i * 3) : 8'h00;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // RAM port / handshake activity counters.
  int   rdIssues = 0;
  int   wrIssues = 0;
  int   ackCount = 0;
  int   ackB2B   = 0;
  logic prevAck  = 1'b0;

  always @(posedge clk) begin
    if (ram_en && !ram_we) rdIssues++;
    if (ram_en && ram_we)  wrIssues++;
    if (wr_ack)            ackCount++;
    if (wr_ack && prevAck) ackB2B++;
    prevAck = wr_ack;
  end

  // Expected framebuffer contents and captured pixels.
  logic [7:0] model  [FB_PIXELS];
  logic [7:0] capBuf [FB_PIXELS];

  typedef struct {
    logic       fs;
    logic       ce;
    logic       act;
    logic       chk;
    logic [7:0] expPix;
    logic       expUnd;
  } vec_t;

  vec_t vecs [64];
  int   nVec;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    frame_start = v.fs;
    pix_ce      = v.ce;
    active      = v.act;
    tick();
  endtask

  task automatic addVec(input logic fs, input logic ce, input logic act,
                        input logic chk, input logic [7:0] expPix, input logic expUnd);
    vecs[nVec] = '{fs: fs, ce: ce, act: act, chk: chk, expPix: expPix, expUnd: expUnd};
    nVec++;
  endtask

  // frame_start, six prefetch cycles, then nPix pulses on every 2nd clk.
  task automatic runFrame(input int nPix);
    frame_start = 1'b1; pix_ce = 1'b0; active = 1'b0;
    tick();
    frame_start = 1'b0;
    repeat (6) tick();
    for (int i = 0; i < nPix; i++) begin
      pix_ce = 1'b1; active = 1'b1;
      tick();
      capBuf[i] = pix_out;
      pix_ce = 1'b0;
      tick();
    end
    active = 1'b0;
  endtask

  task automatic checkFrame(input string tag, input int skipIdx);
    for (int i = 0; i < FB_PIXELS; i++) begin
      if (i != skipIdx) checkOutput($sformatf("%s_pix%0d", tag, i), 32'(capBuf[i]), 32'(model[i]));
    end
  endtask

  task automatic waitAck(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!wr_ack && lat < 20);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base, baseW, baseA, baseB, lat, k, ackLat, found, bad;
    logic wrPend, stopW;

    for (int i = 0; i < FB_PIXELS; i++) model[i] = 8'(i * 3);
    rst = 1'b1; preloadReq = 1'b1;
    pix_ce = 1'b0; frame_start = 1'b0; active = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1 preloadReq = 1'b0;

    // ---- reset state ----
    checkOutput("rst_pix_out",   32'(pix_out),   0);
    checkOutput("rst_underrun",  32'(underrun),  0);
    checkOutput("rst_wr_ack",    32'(wr_ack),    0);
    checkOutput("rst_ram_en",    32'(ram_en),    0);
    checkOutput("rst_ram_we",    32'(ram_we),    0);
    checkOutput("rst_ram_addr",  32'(ram_addr),  0);
    checkOutput("rst_ram_wdata", 32'(ram_wdata), 0);
    #2 rst = 1'b0;
    tick();

    base = rdIssues;
    repeat (5) tick();
    checkOutput("idle_no_reads", 32'(rdIssues - base), 0);

    // ---- test 1: one clean frame from the vector table ----
    nVec = 0;
    addVec(1, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 6; i++) addVec(0, 0, 0, 1, 8'h00, 0);
    for (int i = 0; i < FB_PIXELS; i++) begin
      addVec(0, 1, 1, 1, model[i], 0);
      addVec(0, 0, 1, 1, model[i], 0);
    end
    addVec(0, 1, 0, 1, 8'h00, 0);
    addVec(0, 0, 0, 1, 8'h00, 0);

    base = rdIssues;
    for (int i = 0; i < nVec; i++) begin
      applyStimulus(vecs[i]);
      if (vecs[i].chk) begin
        checkOutput($sformatf("t1_pix[%0d]", i), 32'(pix_out),  32'(vecs[i].expPix));
        checkOutput($sformatf("t1_und[%0d]", i), 32'(underrun), 32'(vecs[i].expUnd));
      end
    end
    pix_ce = 1'b0; active = 1'b0; frame_start = 1'b0;
    repeat (4) tick();
    checkOutput("t1_read_count", 32'(rdIssues - base), FB_PIXELS);
    repeat (6) tick();
    checkOutput("t1_done_no_more_reads", 32'(rdIssues - base), FB_PIXELS);

    // ---- test 2: single write during prefetch ----
    baseW = wrIssues;
    lat = 0;
    fork
      runFrame(FB_PIXELS);
      begin
        tick();
        wr_addr = 8'd5; wr_data = 8'hA5; wr_req = 1'b1;
        waitAck(lat);
        wr_req = 1'b0;
      end
    join
    checkOutput("t2_ack_seen",      32'(wr_ack === 1'b1 || lat < 20), 1);
    checkOutput("t2_ack_in_time",   32'(lat <= MAX_WAIT + 1), 1);
    checkFrame("t2f1", 5);
    checkOutput("t2f1_pix5_either", 32'(capBuf[5] == model[5] || capBuf[5] == 8'hA5), 1);
    checkOutput("t2f1_underrun",    32'(underrun), 0);
    repeat (4) tick();
    checkOutput("t2_one_write",     32'(wrIssues - baseW), 1);
    model[5] = 8'hA5;
    runFrame(FB_PIXELS);
    checkFrame("t2f2", -1);
    checkOutput("t2f2_underrun",    32'(underrun), 0);

    // ---- test 3: back-to-back writes over three frames ----
    baseW = wrIssues; baseA = ackCount; baseB = ackB2B;
    k = 0; stopW = 1'b0;
    fork
      begin
        for (int f = 0; f < 3; f++) begin
          runFrame(FB_PIXELS);
          checkFrame($sformatf("t3f%0d", f), -1);
          checkOutput($sformatf("t3f%0d_underrun", f), 32'(underrun), 0);
        end
        stopW = 1'b1;
      end
      begin
        wr_addr = 8'd100; wr_data = 8'd1; wr_req = 1'b1;
        for (int it = 0; it < 3000 && !stopW; it++) begin
          tick();
          if (wr_ack) begin
            k++;
            wr_addr = 8'(100 + k);
            wr_data = 8'(k + 1);
          end
        end
        wr_req = 1'b0;
      end
    join
    repeat (4) tick();
    checkOutput("t3_enough_writes", 32'(k >= 10), 1);
    checkOutput("t3_ack_count",     32'(ackCount - baseA), 32'(k));
    checkOutput("t3_write_count",   32'(wrIssues - baseW), 32'(k));
    checkOutput("t3_no_b2b_ack",    32'(ackB2B - baseB), 0);
    bad = 0;
    for (int j = 0; j < k; j++) if (mem[100 + j] !== 8'(j + 1)) bad++;
    checkOutput("t3_ram_contents",  32'(bad), 0);

    // ---- test 4: over-rate pix_ce, forced write after MAX_WAIT denials ----
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    repeat (6) tick();
    pix_ce = 1'b1; active = 1'b1;
    wrPend = 1'b0; lat = 0; ackLat = 0;
    for (int p = 0; p < 24; p++) begin
      tick();
      if (p < 4) checkOutput($sformatf("t4_pix%0d", p), 32'(pix_out), 32'(model[p]));
      if (wrPend) begin
        lat++;
        if (wr_ack) begin
          wrPend = 1'b0; wr_req = 1'b0; ackLat = lat;
        end
      end
      if (p == 3) begin
        wr_addr = 8'd200; wr_data = 8'h5A; wr_req = 1'b1; wrPend = 1'b1; lat = 0;
      end
    end
    wr_req = 1'b0;
    checkOutput("t4_forced_ack_latency", 32'(ackLat), MAX_WAIT + 1);
    checkOutput("t4_underrun",           32'(underrun), 1);
    checkOutput("t4_pix_empty",          32'(pix_out), 0);
    active = 1'b0;
    repeat (3) tick();
    pix_ce = 1'b0;
    checkOutput("t4_underrun_sticky",    32'(underrun), 1);
    checkOutput("t4_forced_write_data",  32'(mem[200]), 32'h5A);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    checkOutput("t4_underrun_cleared",   32'(underrun), 0);

    // ---- test 5: frame_start mid-frame with pop and read in flight ----
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    repeat (6) tick();
    for (int i = 0; i < 5; i++) begin
      pix_ce = 1'b1; active = 1'b1; tick();
      checkOutput($sformatf("t5_pre_pix%0d", i), 32'(pix_out), 32'(model[i]));
      pix_ce = 1'b0; tick();
    end
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      if (ram_en && !ram_we) found = 1;
      else tick();
    end
    checkOutput("t5_read_in_flight", 32'(found), 1);
    frame_start = 1'b1; pix_ce = 1'b1; active = 1'b1;
    tick();
    frame_start = 1'b0; pix_ce = 1'b0; active = 1'b0;
    repeat (6) tick();
    for (int i = 0; i < 3; i++) begin
      pix_ce = 1'b1; active = 1'b1; tick();
      checkOutput($sformatf("t5_post_pix%0d", i), 32'(pix_out), 32'(model[i]));
      pix_ce = 1'b0; tick();
    end
    active = 1'b0;
    checkOutput("t5_underrun", 32'(underrun), 0);

    // ---- test 6: asynchronous reset mid-FETCH ----
    tick();
    checkOutput("t6_pix_before_rst", 32'(pix_out), 32'(model[2]));
    #3 rst = 1'b1;
    #1;
    checkOutput("t6_rst_pix_out",   32'(pix_out),   0);
    checkOutput("t6_rst_underrun",  32'(underrun),  0);
    checkOutput("t6_rst_wr_ack",    32'(wr_ack),    0);
    checkOutput("t6_rst_ram_en",    32'(ram_en),    0);
    checkOutput("t6_rst_ram_we",    32'(ram_we),    0);
    checkOutput("t6_rst_ram_addr",  32'(ram_addr),  0);
    checkOutput("t6_rst_ram_wdata", 32'(ram_wdata), 0);
    #2 rst = 1'b0;
    tick();
    base = rdIssues; baseW = wrIssues;
    repeat (10) tick();
    checkOutput("t6_idle_no_reads", 32'(rdIssues - base), 0);
    wr_addr = 8'd7; wr_data = 8'hC3; wr_req = 1'b1;
    waitAck(lat);
    wr_req = 1'b0;
    checkOutput("t6_write_latency", 32'(lat), 1);
    repeat (3) tick();
    checkOutput("t6_write_count",   32'(wrIssues - baseW), 1);
    checkOutput("t6_still_no_reads", 32'(rdIssues - base), 0);
    checkOutput("t6_write_data",    32'(mem[7]), 32'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
